// File: rtl/maze_pkg.sv
// maze_pkg: shared sizes, FSM state encoding and default force-open masks
//   H_N, V_N, NBITS          : maze geometry and wall-mask width
//   ST_* / state_t           : 3-bit scheduler state encoding
//   OPEN_H_DEF, OPEN_V_DEF   : wall bits that are always forced open
package maze_pkg;
    localparam int H_N = 5;
    localparam int V_N = 5;
    localparam int NBITS = H_N * V_N;
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_FETCH_H = 3'd1;
    localparam logic [2:0] ST_FETCH_V = 3'd2;
    localparam logic [2:0] ST_WAIT_FRAME = 3'd3;
    localparam logic [2:0] ST_COMMIT = 3'd4;
    typedef enum logic [2:0] {
        IDLE = ST_IDLE,
        FETCH_H = ST_FETCH_H,
        FETCH_V = ST_FETCH_V,
        WAIT_FRAME = ST_WAIT_FRAME,
        COMMIT = ST_COMMIT
    } state_t;
    localparam logic [NBITS-1:0] OPEN_H_DEF = 25'h0000001;
    localparam logic [NBITS-1:0] OPEN_V_DEF = 25'h1000000;
endpackage

// File: rtl/maze_wall_scheduler_if.sv
// maze_wall_scheduler_if: the two LFSR valid/ready random-word channels
//   rnd_h_data/valid/ready : horizontal-wall random word channel
//   rnd_v_data/valid/ready : vertical-wall random word channel
//   master = LFSR source side, slave = scheduler side
interface maze_wall_scheduler_if;
    logic [maze_pkg::NBITS-1:0] rnd_h_data;
    logic [maze_pkg::NBITS-1:0] rnd_v_data;
    logic rnd_h_valid;
    logic rnd_h_ready;
    logic rnd_v_valid;
    logic rnd_v_ready;
    modport master (
        output rnd_h_data, rnd_h_valid, rnd_v_data, rnd_v_valid,
        input rnd_h_ready, rnd_v_ready
    );
    modport slave (
        input rnd_h_data, rnd_h_valid, rnd_v_data, rnd_v_valid,
        output rnd_h_ready, rnd_v_ready
    );
endinterface

// File: rtl/rand_fetch_port.sv
// rand_fetch_port: one valid/ready capture register, ready acts as the enable
//   clk, rst_n   : clock, asynchronous active-low reset
//   valid, ready : handshake; a word is taken when both are high
//   data         : incoming random word
//   fire         : handshake completes this cycle
//   cap          : last captured word (cleared by reset)
module rand_fetch_port
    import maze_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid,
    input  logic             ready,
    input  logic [NBITS-1:0] data,
    output logic             fire,
    output logic [NBITS-1:0] cap
);
    assign fire = valid & ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cap <= '0;
        else if (fire) cap <= data;
    end
endmodule

// File: rtl/maze_wall_scheduler.sv
// maze_wall_scheduler: fetches h/v random words and commits wall masks at frame start
//   pixel_clk, reset      : clock, asynchronous active-low reset
//   regen_req             : one-cycle request for a new maze
//   frame_start           : one-cycle pulse at the first blanked line
//   rnd (slave)           : h and v random-word valid/ready channels
//   wall_h, wall_v        : committed wall masks, 1 = wall drawn
//   busy                  : scheduler not idle
//   commit_pulse          : high during the cycle the masks are loaded
module maze_wall_scheduler
    import maze_pkg::*;
#(
    parameter int               AUTO_FRAMES = 60,
    parameter logic [NBITS-1:0] OPEN_H      = OPEN_H_DEF,
    parameter logic [NBITS-1:0] OPEN_V      = OPEN_V_DEF
) (
    input  logic                 pixel_clk,
    input  logic                 reset,
    input  logic                 regen_req,
    input  logic                 frame_start,
    maze_wall_scheduler_if.slave rnd,
    output logic [NBITS-1:0]     wall_h,
    output logic [NBITS-1:0]     wall_v,
    output logic                 busy,
    output logic                 commit_pulse
);
    localparam bit AUTO_EN = AUTO_FRAMES > 0;
    localparam logic [7:0] AUTO_LAST = 8'(AUTO_EN ? AUTO_FRAMES - 1 : 0);

    state_t           state;
    logic             pending;
    logic             h_ready;
    logic             v_ready;
    logic             h_fire;
    logic             v_fire;
    logic [7:0]       frame_cnt;
    logic [NBITS-1:0] cap_h;
    logic [NBITS-1:0] cap_v;
    logic             auto_hit;
    logic             trigger;

    assign rnd.rnd_h_ready = h_ready;
    assign rnd.rnd_v_ready = v_ready;
    assign auto_hit = AUTO_EN && frame_start && frame_cnt == AUTO_LAST;
    assign trigger = regen_req | pending | auto_hit;

    rand_fetch_port u_fetch_h (
        .clk  (pixel_clk),
        .rst_n(reset),
        .valid(rnd.rnd_h_valid),
        .ready(h_ready),
        .data (rnd.rnd_h_data),
        .fire (h_fire),
        .cap  (cap_h)
    );

    rand_fetch_port u_fetch_v (
        .clk  (pixel_clk),
        .rst_n(reset),
        .valid(rnd.rnd_v_valid),
        .ready(v_ready),
        .data (rnd.rnd_v_data),
        .fire (v_fire),
        .cap  (cap_v)
    );

    always_ff @(posedge pixel_clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            wall_h <= '0;
            wall_v <= '0;
            h_ready <= 1'b0;
            v_ready <= 1'b0;
            busy <= 1'b0;
            commit_pulse <= 1'b0;
            pending <= 1'b0;
            frame_cnt <= '0;
        end else begin
            commit_pulse <= 1'b0;
            case (state)
                IDLE: begin
                    if (trigger) begin
                        state <= FETCH_H;
                        h_ready <= 1'b1;
                        busy <= 1'b1;
                        pending <= 1'b0;
                        frame_cnt <= '0;
                    end else if (frame_start && frame_cnt != 8'hFF) begin
                        frame_cnt <= frame_cnt + 8'd1;
                    end
                end
                FETCH_H: begin
                    if (h_fire) begin
                        state <= FETCH_V;
                        h_ready <= 1'b0;
                        v_ready <= 1'b1;
                    end
                end
                FETCH_V: begin
                    if (v_fire) begin
                        state <= WAIT_FRAME;
                        v_ready <= 1'b0;
                    end
                end
                WAIT_FRAME: begin
                    if (frame_start) begin
                        state <= COMMIT;
                        commit_pulse <= 1'b1;
                    end
                end
                COMMIT: begin
                    wall_h <= ~cap_h & ~OPEN_H;
                    wall_v <= ~cap_v & ~OPEN_V;
                    state <= IDLE;
                    busy <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    h_ready <= 1'b0;
                    v_ready <= 1'b0;
                    busy <= 1'b0;
                end
            endcase
            // A request arriving while a sequence runs (COMMIT included) is held one-deep
            if (state != IDLE && regen_req) pending <= 1'b1;
        end
    end
endmodule

// File: tb/tb_maze_wall_scheduler.sv
// tb_maze_wall_scheduler: directed bench for two schedulers (auto 60 and auto 3) with a flag-level model
module tb_maze_wall_scheduler;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic req = 1'b0;
    logic fs = 1'b0;
    logic hv = 1'b0;
    logic vv = 1'b0;
    logic [24:0] hd = '0;
    logic [24:0] vd = '0;
    logic [24:0] wh_a, wv_a, wh_b, wv_b;
    logic busy_a, busy_b, cp_a, cp_b;
    bit run = 1'b0;
    int comp = 0;
    int errs = 0;
    int n_a = 0;
    int n_b = 0;
    int n0a, n0b;

    always #5 clk = ~clk;

    maze_wall_scheduler_if ia();
    maze_wall_scheduler_if ib();
    assign ia.rnd_h_data = hd;
    assign ia.rnd_v_data = vd;
    assign ia.rnd_h_valid = hv;
    assign ia.rnd_v_valid = vv;
    assign ib.rnd_h_data = hd;
    assign ib.rnd_v_data = vd;
    assign ib.rnd_h_valid = hv;
    assign ib.rnd_v_valid = vv;

    maze_wall_scheduler #(.AUTO_FRAMES(60)) dut_a (
        .pixel_clk(clk), .reset(rst_n), .regen_req(req), .frame_start(fs), .rnd(ia.slave),
        .wall_h(wh_a), .wall_v(wv_a), .busy(busy_a), .commit_pulse(cp_a)
    );
    maze_wall_scheduler #(.AUTO_FRAMES(3)) dut_b (
        .pixel_clk(clk), .reset(rst_n), .regen_req(req), .frame_start(fs), .rnd(ib.slave),
        .wall_h(wh_b), .wall_v(wv_b), .busy(busy_b), .commit_pulse(cp_b)
    );

    logic [24:0] o_wh[2], o_wv[2];
    logic o_busy[2], o_cp[2], o_hr[2], o_vr[2];
    assign o_wh[0] = wh_a;
    assign o_wh[1] = wh_b;
    assign o_wv[0] = wv_a;
    assign o_wv[1] = wv_b;
    assign o_busy[0] = busy_a;
    assign o_busy[1] = busy_b;
    assign o_cp[0] = cp_a;
    assign o_cp[1] = cp_b;
    assign o_hr[0] = ia.rnd_h_ready;
    assign o_hr[1] = ib.rnd_h_ready;
    assign o_vr[0] = ia.rnd_v_ready;
    assign o_vr[1] = ib.rnd_v_ready;

    // Model: a job is active, has its h word, has its v word, has seen its frame start
    bit m_act[2], m_gh[2], m_gv[2], m_seen[2], m_pend[2];
    int m_cnt[2];
    logic [24:0] m_ch[2], m_cv[2], m_wh[2], m_wv[2];

    always @(posedge clk or negedge rst_n) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                m_act[k] <= 0; m_gh[k] <= 0; m_gv[k] <= 0; m_seen[k] <= 0; m_pend[k] <= 0;
                m_cnt[k] <= 0; m_wh[k] <= '0; m_wv[k] <= '0;
            end else if (!m_act[k]) begin
                if (req || m_pend[k] || (fs && m_cnt[k] == (k == 0 ? 59 : 2))) begin
                    m_act[k] <= 1; m_gh[k] <= 0; m_gv[k] <= 0; m_seen[k] <= 0;
                    m_pend[k] <= 0; m_cnt[k] <= 0;
                end else if (fs) begin
                    m_cnt[k] <= (m_cnt[k] >= 255) ? 255 : m_cnt[k] + 1;
                end
            end else begin
                if (req) m_pend[k] <= 1;
                if (m_seen[k]) begin
                    m_wh[k] <= ~m_ch[k] & ~25'h0000001;
                    m_wv[k] <= ~m_cv[k] & ~25'h1000000;
                    m_act[k] <= 0;
                    m_seen[k] <= 0;
                end else if (!m_gh[k]) begin
                    if (hv) begin m_gh[k] <= 1; m_ch[k] <= hd; end
                end else if (!m_gv[k]) begin
                    if (vv) begin m_gv[k] <= 1; m_cv[k] <= vd; end
                end else if (fs) begin
                    m_seen[k] <= 1;
                end
            end
        end
    end

    task automatic check(input string name, input int k, input logic [31:0] got, input logic [31:0] exp);
        comp++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s dut%0d t=%0t got %h expected %h", name, k, $time, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (run) begin
            for (int k = 0; k < 2; k++) begin
                check("busy", k, 32'(o_busy[k]), 32'(m_act[k]));
                check("h_ready", k, 32'(o_hr[k]), 32'(m_act[k] && !m_gh[k]));
                check("v_ready", k, 32'(o_vr[k]), 32'(m_act[k] && m_gh[k] && !m_gv[k]));
                check("commit_pulse", k, 32'(o_cp[k]), 32'(m_seen[k]));
                check("wall_h", k, 32'(o_wh[k]), 32'(m_wh[k]));
                check("wall_v", k, 32'(o_wv[k]), 32'(m_wv[k]));
            end
        end
    end

    always @(negedge clk) begin
        if (cp_a) n_a++;
        if (cp_b) n_b++;
    end

    task automatic cyc(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask
    task automatic pulse_req();
        req = 1; cyc(1); req = 0;
    endtask
    task automatic pulse_fs();
        fs = 1; cyc(1); fs = 0;
    endtask

    initial begin
        cyc(3);
        rst_n = 1;
        run = 1;
        // Idle after reset
        cyc(100);
        check("idle_busy", 0, 32'(busy_a), 0);
        check("idle_wall_h", 0, 32'(wh_a), 0);
        check("idle_ready", 1, 32'({ib.rnd_h_ready, ib.rnd_v_ready}), 0);
        // Basic regeneration
        hd = 25'h0F0F0F0; vd = 25'h1555555; hv = 1; vv = 1;
        n0a = n_a;
        pulse_req();
        cyc(19);
        pulse_fs();
        check("cp_after_fs", 0, 32'(cp_a), 1);
        cyc(1);
        check("cp_once", 0, 32'(cp_a), 0);
        check("basic_wall_h", 0, 32'(wh_a), 32'h10F0F0E);
        check("basic_wall_v", 0, 32'(wv_a), 32'h0AAAAAA);
        check("basic_wall_h", 1, 32'(wh_b), 32'h10F0F0E);
        check("model_wall_h", 0, 32'(m_wh[0]), 32'h10F0F0E);
        check("basic_commits", 0, n_a - n0a, 1);
        // Starved h channel
        hv = 0; vv = 0; n0a = n_a;
        pulse_req();
        cyc(24); pulse_fs(); cyc(24);
        check("stall_busy", 0, 32'(busy_a), 1);
        check("stall_h_ready", 0, 32'(ia.rnd_h_ready), 1);
        check("stall_v_ready", 0, 32'(ia.rnd_v_ready), 0);
        hd = 25'h0123456; hv = 1; cyc(1); hv = 0;
        check("late_h_capture", 0, 32'({ia.rnd_h_ready, ia.rnd_v_ready}), 32'b01);
        vd = 25'h1ABCDEF; vv = 1; cyc(1); vv = 0;
        check("v_captured", 0, 32'(ia.rnd_v_ready), 0);
        pulse_fs(); cyc(1);
        check("stall_wall_h", 0, 32'(wh_a), 32'h1EDCBA8);
        check("stall_wall_v", 0, 32'(wv_a), 32'h0543210);
        check("stall_commits", 0, n_a - n0a, 1);
        // Pending requests
        hd = 25'h1FFFFFF; vd = 25'h0000000; hv = 1; vv = 1; n0a = n_a;
        pulse_req(); cyc(3);
        pulse_req(); cyc(2); pulse_req();
        pulse_fs();
        req = 1; cyc(1); req = 0;
        check("pend_idle", 0, 32'(busy_a), 0);
        cyc(1);
        check("pend_restart", 0, 32'(busy_a), 1);
        check("pend_h_ready", 0, 32'(ia.rnd_h_ready), 1);
        check("pend_two_commits", 0, n_a - n0a, 1);
        cyc(2); pulse_fs();
        req = 1; cyc(1); req = 0;
        cyc(1);
        check("commit_req_restart", 0, 32'(busy_a), 1);
        check("pend_commits", 0, n_a - n0a, 2);
        cyc(2); pulse_fs(); cyc(5);
        check("pend_done", 0, 32'(busy_a), 0);
        check("pend_total", 0, n_a - n0a, 3);
        check("pend_wall_v", 0, 32'(wv_a), 32'h0FFFFFF);
        // Auto mode
        n0a = n_a; n0b = n_b;
        repeat (12) begin pulse_fs(); cyc(9); end
        check("auto3_commits", 1, n_b - n0b, 3);
        check("auto60_commits", 0, n_a - n0a, 0);
        // Reset mid-sequence
        hv = 1; vv = 0;
        pulse_req(); cyc(1);
        check("rst_pre_v_ready", 0, 32'(ia.rnd_v_ready), 1);
        #2 rst_n = 0; #1;
        check("rst_busy", 0, 32'(busy_a), 0);
        check("rst_v_ready", 0, 32'(ia.rnd_v_ready), 0);
        check("rst_wall_h", 0, 32'(wh_a), 0);
        check("rst_wall_v", 1, 32'(wv_b), 0);
        cyc(2); rst_n = 1;
        n0a = n_a; n0b = n_b;
        pulse_fs(); cyc(3); pulse_fs(); cyc(3);
        check("rst_cnt_b", 1, 32'(busy_b), 0);
        check("rst_idle_a", 0, 32'(busy_a), 0);
        pulse_fs();
        check("rst_auto_b", 1, 32'(busy_b), 1);
        cyc(5);
        check("rst_no_commit_a", 0, n_a - n0a, 0);
        check("rst_no_commit_b", 1, n_b - n0b, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", comp, errs);
        $finish;
    end
endmodule

// File: doc/maze_wall_scheduler.md
Name: maze_wall_scheduler

Overview:
- Sequences regeneration of the maze wall pattern drawn by the VGA map renderer.
- On a request or periodic auto-trigger, it fetches one random word each from the horizontal-wall and vertical-wall LFSR sources over valid/ready handshakes.
- It applies force-open masks and commits both wall masks to the renderer only at a frame start, so a frame never shows a partial update.
- Sits between the LFSR instances and the pixel-colour logic in the pixel clock domain.

Parameters:
- H_N, 5, horizontal cell count.
- V_N, 5, vertical cell count.
- NBITS, H_N*V_N (25), wall-mask width.
- AUTO_FRAMES, 60, frame starts between automatic regenerations; 0 disables auto mode.
- OPEN_H, 25'h0000001, horizontal wall bits always forced open.
- OPEN_V, 25'h1000000, vertical wall bits always forced open.

Ports:
- pixel_clk  in  1  pixel clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- regen_req  in  1  single-cycle pulse requesting a new maze.
- frame_start  in  1  single-cycle pulse at the first blanked line after the visible area.
- rnd_h_data  in  NBITS  horizontal random word.
- rnd_h_valid  in  1  rnd_h_data valid.
- rnd_h_ready  out  1  scheduler accepts rnd_h_data.
- rnd_v_data  in  NBITS  vertical random word.
- rnd_v_valid  in  1  rnd_v_data valid.
- rnd_v_ready  out  1  scheduler accepts rnd_v_data.
- wall_h  out  NBITS  committed horizontal mask; 1 = wall drawn.
- wall_v  out  NBITS  committed vertical mask; 1 = wall drawn.
- busy  out  1  high in any state other than IDLE.
- commit_pulse  out  1  one-cycle pulse on the cycle the masks update.

Behaviour:
- Reset (reset=0, asynchronous):
  - State = IDLE.
  - wall_h = wall_v = 0.
  - rnd_h_ready = rnd_v_ready = busy = commit_pulse = 0.
  - Pending flag and frame counter = 0.
  - A reset mid-sequence discards any captured words; no commit occurs.
- States: IDLE, FETCH_H, FETCH_V, WAIT_FRAME, COMMIT.
- IDLE -> FETCH_H when trigger = regen_req | pending | auto_hit.
  - Entering FETCH_H clears pending and the frame counter.
- FETCH_H:
  - rnd_h_ready = 1 (registered, asserted from the first FETCH_H cycle).
  - On rnd_h_valid & rnd_h_ready, capture the word into cap_h and go to FETCH_V.
  - rnd_h_valid may stay low indefinitely; the state holds and there is no timeout.
- FETCH_V:
  - Same handshake on the v channel.
  - Capture into cap_v, then go to WAIT_FRAME.
  - Only one ready is ever high at a time.
- WAIT_FRAME:
  - On frame_start go to COMMIT.
  - A frame_start in the same cycle as the v capture is not counted; the block waits for the next one.
- COMMIT (one cycle):
  - wall_h <= ~cap_h & ~OPEN_H.
  - wall_v <= ~cap_v & ~OPEN_V.
  - commit_pulse = 1.
  - Next state IDLE.
  - Masks are visible to the renderer from the cycle after COMMIT.
- Latency: with valid held high, regen_req to commit_pulse = 3 cycles plus the wait for the next frame_start.
- Pending request:
  - regen_req while busy sets a one-deep pending flag; further requests while pending are dropped.
  - Pending is served on the cycle after the return to IDLE.
  - regen_req in the COMMIT cycle also sets pending.
- Auto mode (AUTO_FRAMES > 0):
  - The 8-bit frame counter increments on frame_start in IDLE only.
  - auto_hit when count == AUTO_FRAMES-1 and frame_start occur together.
  - The counter saturates rather than wrapping.
- Simultaneous regen_req and auto_hit in IDLE start one sequence; pending is not set.
- Outputs are registered; wall_h and wall_v are stable except in the cycle after COMMIT.

Decomposition:
- Shared package maze_pkg holds:
  - H_N, V_N, NBITS.
  - State encoding (3-bit localparams).
  - Default OPEN_H and OPEN_V.
- Natural sub-module: rand_fetch_port. It is a single valid/ready capture register with an enable, instantiated twice (h and v).
- FSM, pending flag and frame counter stay in the top.

Test Plan:
- Reset then idle: wall_h = wall_v = 0, busy = 0, both readys 0 for 100 cycles.
- regen_req with rnd_h = 25'h0F0F0F0, rnd_v = 25'h1555555, valids high, frame_start 20 cycles later:
  - commit_pulse exactly once, on the cycle after frame_start.
  - wall_h = 25'h10F0F0E; wall_v = 25'h0AAAAAA.
- rnd_h_valid held low for 50 cycles after regen_req:
  - rnd_h_ready stays 1 and the state stays FETCH_H.
  - Raising valid captures on that edge; no frame_start-driven commit before capture.
- Two regen_req pulses during WAIT_FRAME plus one during COMMIT:
  - Exactly two commits in total.
  - The second sequence starts the cycle after IDLE is re-entered.
- AUTO_FRAMES = 3, no requests: a sequence starts on every 3rd frame_start in IDLE; commit_pulse count matches over 12 frames.
- Assert reset during FETCH_V with cap_h loaded:
  - Outputs return to reset values immediately; no commit follows.
  - After release, IDLE with counter 0.
